// File: rtl/lfsr_stream_cipher.sv
// rtl/lfsr_stream_cipher.sv - LFSR stream cipher: seeded encrypt, preamble-driven tap/state discovery for decrypt
module lfsr_stream_cipher #(
    parameter int                    W        = 8,
    parameter int                    NUM_PTRN = 8,
    parameter logic [NUM_PTRN*W-1:0] TAPS     = {8'hf3, 8'hfa, 8'hb2, 8'hb4, 8'hb8, 8'hc6, 8'hd4, 8'he1},
    parameter logic [W-1:0]          PAD      = 8'h20,
    parameter int                    DISC_LEN = 9
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_start,
    input  logic                        i_mode,
    input  logic [W-1:0]                i_seed,
    input  logic [$clog2(NUM_PTRN)-1:0] i_tap_sel,
    input  logic                        i_in_valid,
    output logic                        o_in_ready,
    input  logic [W-1:0]                i_in_data,
    input  logic                        i_in_last,
    output logic                        o_out_valid,
    input  logic                        i_out_ready,
    output logic [W-1:0]                o_out_data,
    output logic                        o_out_last,
    output logic                        o_locked,
    output logic [$clog2(NUM_PTRN)-1:0] o_lock_idx,
    output logic                        o_err,
    output logic                        o_done
);
    localparam int IW = $clog2(NUM_PTRN);
    localparam int KW = $clog2(DISC_LEN + 1);

    typedef enum logic [1:0] {S_IDLE, S_ENC, S_DISC, S_DEC} state_t;

    state_t              r_state, w_state_nxt;
    logic [W-1:0]        r_s, r_tap;
    logic [W-1:0]        r_c [NUM_PTRN];
    logic [NUM_PTRN-1:0] r_alive, w_alive_nxt;
    logic [KW-1:0]       r_k;
    logic                r_fin, r_out_valid, r_out_last, r_done, r_locked, r_err;
    logic [W-1:0]        r_out_data, w_out_byte;
    logic [IW-1:0]       r_lock_idx, w_j;
    logic                w_hs_in, w_hs_out, w_lock_now, w_err_now, w_start;

    function automatic logic [W-1:0] f_step(input logic [W-1:0] s, input logic [W-1:0] t);
        return {s[W-2:0], ^(s & t)};
    endfunction

    // r_fin blocks further input once the final byte has been taken
    assign w_start    = (r_state == S_IDLE) && i_start;
    assign o_in_ready = (r_state != S_IDLE) && !r_fin && (!r_out_valid || i_out_ready);
    assign w_hs_in    = o_in_ready && i_in_valid;
    assign w_hs_out   = r_out_valid && i_out_ready;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_alive_nxt = r_alive;
        w_j         = '0;
        w_lock_now  = 1'b0;
        w_err_now   = 1'b0;
        w_out_byte  = '0;
        case (r_state)
            S_IDLE: if (i_start) w_state_nxt = i_mode ? S_DISC : S_ENC;
            S_ENC:  w_out_byte = i_in_data ^ r_s;
            S_DISC: begin
                if (r_k == '0) begin
                    w_out_byte = PAD;
                end else begin
                    for (int i = 0; i < NUM_PTRN; i++)
                        w_alive_nxt[i] = r_alive[i] && ((i_in_data ^ r_c[i]) == PAD);
                    for (int i = NUM_PTRN - 1; i >= 0; i--)
                        if (w_alive_nxt[i]) w_j = IW'(i);
                    w_err_now  = ~|w_alive_nxt;
                    w_out_byte = i_in_data ^ r_c[w_j];
                end
                w_lock_now = w_err_now || (r_k == KW'(DISC_LEN - 1)) || i_in_last;
                if (w_hs_in && w_lock_now) w_state_nxt = S_DEC;
            end
            S_DEC:  w_out_byte = i_in_data ^ r_c[r_lock_idx];
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_hs_out && r_out_last) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_s         <= '0;
            r_tap       <= '0;
            r_alive     <= '0;
            r_k         <= '0;
            r_fin       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
            r_done      <= 1'b0;
            r_locked    <= 1'b0;
            r_lock_idx  <= '0;
            r_err       <= 1'b0;
            for (int i = 0; i < NUM_PTRN; i++) r_c[i] <= '0;
        end else begin
            r_done <= w_hs_out && r_out_last;
            if (w_hs_out) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
            if (w_start) begin
                r_err      <= 1'b0;
                r_locked   <= 1'b0;
                r_lock_idx <= '0;
                r_fin      <= 1'b0;
                r_k        <= '0;
                r_alive    <= '1;
                r_s        <= i_seed;
                r_tap      <= TAPS[i_tap_sel*W +: W];
            end
            if (w_hs_in) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_out_byte;
                r_out_last  <= i_in_last;
                r_fin       <= i_in_last;
                case (r_state)
                    S_ENC: r_s <= f_step(r_s, r_tap);
                    S_DISC: begin
                        r_alive <= w_alive_nxt;
                        if (r_k != KW'(DISC_LEN - 1)) r_k <= r_k + KW'(1);
                        // byte 0 seeds every candidate from the known plaintext
                        for (int i = 0; i < NUM_PTRN; i++)
                            r_c[i] <= f_step((r_k == '0) ? (i_in_data ^ PAD) : r_c[i], TAPS[i*W +: W]);
                        if (w_lock_now) begin
                            r_locked   <= 1'b1;
                            r_lock_idx <= w_j;
                            r_err      <= w_err_now;
                        end
                    end
                    S_DEC:
                        for (int i = 0; i < NUM_PTRN; i++)
                            r_c[i] <= f_step(r_c[i], TAPS[i*W +: W]);
                    default: ;
                endcase
            end
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_last  = r_out_last;
    assign o_locked    = r_locked;
    assign o_lock_idx  = r_lock_idx;
    assign o_err       = r_err;
    assign o_done      = r_done;
endmodule

// File: tb/tb_lfsr_stream_cipher.sv
// tb/tb_lfsr_stream_cipher.sv - randomized self-checking bench for lfsr_stream_cipher
module tb_lfsr_stream_cipher;
    typedef logic [7:0] bq_t [$];
    localparam logic [7:0] PAD = 8'h20;
    localparam int DISC_LEN = 9;

    logic       i_clk = 0, i_reset = 0, i_start = 0, i_mode = 0;
    logic [7:0] i_seed = 0;
    logic [2:0] i_tap_sel = 0;
    logic       i_in_valid = 0, i_in_last = 0, i_out_ready = 1;
    logic [7:0] i_in_data = 0;
    logic       o_in_ready, o_out_valid, o_out_last, o_locked, o_err, o_done;
    logic [7:0] o_out_data;
    logic [2:0] o_lock_idx;

    int n_chk = 0, n_pass = 0;
    logic [7:0] taps [8] = '{8'he1, 8'hd4, 8'hc6, 8'hb8, 8'hb4, 8'hb2, 8'hfa, 8'hf3};

    lfsr_stream_cipher dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_mode(i_mode),
        .i_seed(i_seed), .i_tap_sel(i_tap_sel), .i_in_valid(i_in_valid),
        .o_in_ready(o_in_ready), .i_in_data(i_in_data), .i_in_last(i_in_last),
        .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_data(o_out_data),
        .o_out_last(o_out_last), .o_locked(o_locked), .o_lock_idx(o_lock_idx),
        .o_err(o_err), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [7:0] m_step(input logic [7:0] s, input logic [7:0] t);
        return ((s * 2) % 256) + ($countones(s & t) % 2);
    endfunction

    // keystream of every candidate is precomputed, then survival is decided byte by byte
    task automatic model(input bit mode, input logic [7:0] seed, input int tsel, input bq_t msg,
                         output bq_t exp, output bit lk, output int li, output bit er);
        logic [7:0] ks [8][256];
        bit   alive [8];
        logic [7:0] s;
        int   n, lock, j;
        bit   none;
        exp = {};
        n = msg.size();
        lk = 0; li = 0; er = 0;
        if (!mode) begin
            s = seed;
            for (int k = 0; k < n; k++) begin
                exp.push_back(msg[k] ^ s);
                s = m_step(s, taps[tsel]);
            end
            return;
        end
        for (int i = 0; i < 8; i++) begin
            alive[i] = 1;
            ks[i][0] = msg[0] ^ PAD;
            for (int k = 1; k < n; k++) ks[i][k] = m_step(ks[i][k-1], taps[i]);
        end
        lock = -1;
        for (int k = 0; k < n; k++) begin
            if (lock >= 0) begin
                exp.push_back(msg[k] ^ ks[lock][k]);
            end else begin
                j = 0; none = 0;
                if (k == 0) begin
                    exp.push_back(PAD);
                end else begin
                    j = -1;
                    for (int i = 0; i < 8; i++)
                        if (alive[i] && ((msg[k] ^ ks[i][k]) != PAD)) alive[i] = 0;
                    for (int i = 7; i >= 0; i--) if (alive[i]) j = i;
                    none = (j < 0);
                    if (none) j = 0;
                    exp.push_back(msg[k] ^ ks[j][k]);
                end
                if (none || k == DISC_LEN - 1 || k == n - 1) begin
                    lock = j; er = none;
                end
            end
        end
        lk = 1; li = lock;
    endtask

    // bp: 0 always ready, 1 random ready, 2 ready held low for 5 cycles mid-stream
    task automatic run_msg(input string tag, input bit mode, input logic [7:0] seed, input logic [2:0] tsel,
                           input bq_t msg, input bq_t exp, input bit e_lk, input int e_li, input bit e_er,
                           input int bp, input bit poke);
        int idx, nout, cyc, tail, ndone, budget;
        bit prev_stall;
        logic [7:0] prev_data;
        logic prev_last;
        idx = 0; nout = 0; cyc = 0; tail = 0; ndone = 0; prev_stall = 0;
        prev_data = 0; prev_last = 0;
        budget = 40 * msg.size() + 60;
        @(negedge i_clk);
        i_start = 1; i_mode = mode; i_seed = seed; i_tap_sel = tsel;
        i_in_valid = 0; i_in_last = 0; i_out_ready = 1;
        @(negedge i_clk);
        while (cyc < budget && !(nout >= exp.size() && tail >= 3)) begin
            if (prev_stall) begin
                chk({tag, "_hold_valid"}, o_out_valid, 1);
                chk({tag, "_hold_data"}, o_out_data, prev_data);
                chk({tag, "_hold_last"}, o_out_last, prev_last);
            end
            if (nout >= exp.size()) tail++;
            if (o_done) ndone++;
            case (bp)
                0: i_out_ready = 1;
                1: i_out_ready = ($urandom_range(0, 3) != 0);
                default: i_out_ready = !(cyc >= 4 && cyc < 9);
            endcase
            if (idx < msg.size()) begin
                i_in_valid = (bp == 0) ? 1'b1 : ($urandom_range(0, 4) != 0);
                i_in_data  = msg[idx];
                i_in_last  = (idx == msg.size() - 1);
            end else begin
                i_in_valid = 0;
                i_in_data  = 8'($urandom);
                i_in_last  = 0;
            end
            i_start = poke && idx > 0 && idx < msg.size() && ($urandom_range(0, 3) == 0);
            if (poke) begin
                i_mode = 1; i_seed = 8'($urandom); i_tap_sel = 3'($urandom);
            end
            #1;
            if (!i_out_ready && o_out_valid) chk({tag, "_bp_in_ready"}, o_in_ready, 0);
            if (i_in_valid && o_in_ready) idx++;
            if (o_out_valid && i_out_ready) begin
                if (nout < exp.size()) begin
                    chk({tag, "_data"}, o_out_data, exp[nout]);
                    chk({tag, "_last"}, o_out_last, (nout == exp.size() - 1));
                end else begin
                    chk({tag, "_extra_out"}, 1, 0);
                end
                nout++;
            end
            prev_stall = o_out_valid && !i_out_ready;
            prev_data  = o_out_data;
            prev_last  = o_out_last;
            @(negedge i_clk);
            cyc++;
        end
        i_in_valid = 0; i_start = 0; i_in_last = 0; i_out_ready = 1;
        chk({tag, "_count"}, nout, exp.size());
        chk({tag, "_done_pulses"}, ndone, 1);
        chk({tag, "_locked"}, o_locked, e_lk);
        chk({tag, "_lock_idx"}, o_lock_idx, e_li);
        chk({tag, "_err"}, o_err, e_er);
        chk({tag, "_idle_in_ready"}, o_in_ready, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, o_out_valid, 0);
        chk({tag, "_out_data"}, o_out_data, 0);
        chk({tag, "_out_last"}, o_out_last, 0);
        chk({tag, "_done"}, o_done, 0);
        chk({tag, "_locked"}, o_locked, 0);
        chk({tag, "_lock_idx"}, o_lock_idx, 0);
        chk({tag, "_err"}, o_err, 0);
        chk({tag, "_in_ready"}, o_in_ready, 0);
    endtask

    initial begin
        bq_t m, e, pl;
        bit lk, er;
        int li, ts, plen;
        logic [7:0] sd;
        string word;

        repeat (3) @(negedge i_clk);
        #1 check_reset_outputs("por");
        i_reset = 1;

        m = '{8'h20, 8'h20, 8'h20};
        e = '{8'h21, 8'h23, 8'h27};
        run_msg("enc_dir", 0, 8'h01, 3'd0, m, e, 0, 0, 0, 0, 0);

        pl = {};
        for (int i = 0; i < 12; i++) pl.push_back(PAD);
        word = "Knowledge";
        for (int i = 0; i < word.len(); i++) pl.push_back(word[i]);
        model(0, 8'h5A, 1, pl, m, lk, li, er);
        run_msg("dec_dir", 1, 8'h00, 3'd0, m, pl, 1, 1, 0, 0, 0);

        m = {};
        for (int i = 0; i < 10; i++) m.push_back((i % 2) ? 8'hFF : 8'h00);
        model(1, 0, 0, m, e, lk, li, er);
        run_msg("disc_fail", 1, 8'h00, 3'd0, m, e, lk, li, er, 1, 0);

        pl = '{PAD, PAD, PAD, PAD, PAD};
        sd = 8'($urandom); ts = $urandom_range(0, 7);
        model(0, sd, ts, pl, m, lk, li, er);
        model(1, 0, 0, m, e, lk, li, er);
        run_msg("early_last", 1, 8'h00, 3'd0, m, e, lk, li, er, 0, 0);

        pl = {};
        for (int i = 0; i < 10; i++) pl.push_back(PAD);
        for (int i = 0; i < 12; i++) pl.push_back(8'($urandom));
        sd = 8'($urandom); ts = $urandom_range(0, 7);
        model(0, sd, ts, pl, m, lk, li, er);
        model(1, 0, 0, m, e, lk, li, er);
        run_msg("bp_hold", 1, 8'h00, 3'd0, m, e, lk, li, er, 2, 0);

        for (int r = 0; r < 6; r++) begin
            sd = 8'($urandom); ts = $urandom_range(0, 7);
            pl = {};
            plen = $urandom_range(9, 14);
            for (int i = 0; i < plen; i++) pl.push_back(PAD);
            for (int i = 0, n = $urandom_range(1, 10); i < n; i++) pl.push_back(8'($urandom));
            model(0, sd, ts, pl, m, lk, li, er);
            if (r % 2) begin
                model(1, 0, 0, m, e, lk, li, er);
                run_msg("rnd_dec", 1, 8'h00, 3'd0, m, e, lk, li, er, 1, 0);
            end else begin
                run_msg("rnd_enc", 0, sd, 3'(ts), pl, m, 0, 0, 0, 1, 0);
            end
        end

        pl = {};
        for (int i = 0; i < 12; i++) pl.push_back(PAD);
        for (int i = 0; i < 10; i++) pl.push_back(8'($urandom));
        model(0, 8'($urandom), $urandom_range(0, 7), pl, m, lk, li, er);
        @(negedge i_clk);
        i_start = 1; i_mode = 1; i_out_ready = 1;
        @(negedge i_clk);
        i_start = 0; i_in_valid = 1;
        for (int k = 0; k < 14; k++) begin
            i_in_data = m[k]; i_in_last = 0;
            @(negedge i_clk);
        end
        chk("pre_reset_locked", o_locked, 1);
        i_reset = 0;
        #1 check_reset_outputs("mid_reset");
        repeat (2) @(negedge i_clk);
        check_reset_outputs("mid_reset_hold");
        i_in_valid = 0;
        i_reset = 1;

        pl = {};
        for (int i = 0; i < 16; i++) pl.push_back(8'($urandom));
        sd = 8'($urandom); ts = $urandom_range(0, 7);
        model(0, sd, ts, pl, e, lk, li, er);
        run_msg("enc_poke", 0, sd, 3'(ts), pl, e, 0, 0, 0, 1, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
